// File: rtl/cpu_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_io_pkg
// Description : Shared types and constants for the CPU I/O controller:
//               input-handshake state encoding, default opcodes, byte width.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_io_pkg;

    localparam int c_BYTE_W = 8;

    // Input-handshake FSM state type and encoding
    typedef logic [1:0] io_state_t;
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_WAIT    = 2'd1;
    localparam logic [1:0] c_ST_PRESENT = 2'd2;
    localparam logic [1:0] c_ST_RELEASE = 2'd3;

    // Default instruction opcodes that touch the I/O path
    localparam logic [3:0] c_IN_OPCODE_DEF  = 4'b1010;
    localparam logic [3:0] c_OUT_OPCODE_DEF = 4'b1011;

endpackage
`default_nettype wire

// File: rtl/io_fifo.sv
`default_nettype none
// ============================================================================
// Module      : io_fifo
// Description : Synchronous FIFO with combinational head read. Push to a full
//               FIFO is dropped unless a pop happens in the same cycle; pop of
//               an empty FIFO is ignored. DEPTH must be a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module io_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int              c_AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW:0]   c_FULL_CNT = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
    assign w_pop_ok  = i_pop && (r_count != '0);
    assign w_push_ok = i_push && ((r_count != c_FULL_CNT) || w_pop_ok);

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == c_FULL_CNT);
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/cpu_io_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu_io_controller
// Description : Bridges a host to a small CPU. Host bytes are queued and
//               presented to the CPU with an enter strobe when it executes
//               IN_OPCODE; CPU result bytes are captured once per OUT_OPCODE
//               instruction into an output queue for the host.
//               Optional build macro CPU_IO_CHECK_EN adds an expected-result
//               queue with pass/fail counters and an all_pass verdict.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_io_controller
    import cpu_io_pkg::*;
#(
    parameter logic [3:0] IN_OPCODE    = c_IN_OPCODE_DEF,
    parameter logic [3:0] OUT_OPCODE   = c_OUT_OPCODE_DEF,
    parameter int         DEPTH        = 4,
    parameter int         ENTER_CYCLES = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_wr,
    input  logic [c_BYTE_W-1:0] in_data,
    output logic                in_full,
    input  logic [3:0]          opcode,
    input  logic [c_BYTE_W-1:0] cpu_out,
    input  logic                cpu_done,
    output logic [c_BYTE_W-1:0] user_in,
    output logic                enter,
    input  logic                out_rd,
    output logic [c_BYTE_W-1:0] out_data,
    output logic                out_empty,
    output logic                stall
`ifdef CPU_IO_CHECK_EN
    ,
    input  logic                exp_wr,
    input  logic [c_BYTE_W-1:0] exp_data,
    output logic [3:0]          pass_count,
    output logic [3:0]          fail_count,
    output logic                all_pass
`endif
);

    localparam logic [3:0] c_ENTER_LAST = 4'(ENTER_CYCLES - 1);

    io_state_t           r_state;
    logic [3:0]          r_enter_cnt;
    logic                r_enter;
    logic [c_BYTE_W-1:0] r_user_in;
    logic                r_prev_out_op;

    logic                w_in_empty;
    logic [c_BYTE_W-1:0] w_in_head;
    logic                w_in_pop;
    logic                w_out_full;
    logic                w_capture;
    logic                w_out_push;

    // The head byte is retired on the last cycle of its enter strobe
    assign w_in_pop = (r_state == c_ST_PRESENT) && (r_enter_cnt == c_ENTER_LAST);

    io_fifo #(.DEPTH(DEPTH), .WIDTH(c_BYTE_W)) u_in_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (in_wr),
        .i_pop   (w_in_pop),
        .i_din   (in_data),
        .o_dout  (w_in_head),
        .o_full  (in_full),
        .o_empty (w_in_empty)
    );

    // Input handshake: wait for data, strobe it in, hold until the IN ends
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_enter_cnt <= '0;
            r_enter     <= 1'b0;
            r_user_in   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (opcode == IN_OPCODE) r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    if (!w_in_empty) begin
                        r_state     <= c_ST_PRESENT;
                        r_enter_cnt <= '0;
                        r_enter     <= 1'b1;
                        r_user_in   <= w_in_head;
                    end
                end
                c_ST_PRESENT: begin
                    if (r_enter_cnt == c_ENTER_LAST) begin
                        r_state <= c_ST_RELEASE;
                        r_enter <= 1'b0;
                    end else begin
                        r_enter_cnt <= r_enter_cnt + 1'b1;
                    end
                end
                c_ST_RELEASE: begin
                    if (opcode != IN_OPCODE) r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign enter   = r_enter;
    assign user_in = r_user_in;
    assign stall   = (r_state == c_ST_WAIT) && w_in_empty;

    // Remember last cycle's opcode so a multi-cycle OUT captures only once
    always_ff @(posedge clock) begin
        if (reset) r_prev_out_op <= 1'b0;
        else       r_prev_out_op <= (opcode == OUT_OPCODE);
    end

    assign w_capture  = (opcode == OUT_OPCODE) && !r_prev_out_op;
    // A capture into a full queue is lost unless the host frees a slot now
    assign w_out_push = w_capture && (!w_out_full || out_rd);

    io_fifo #(.DEPTH(DEPTH), .WIDTH(c_BYTE_W)) u_out_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (w_out_push),
        .i_pop   (out_rd),
        .i_din   (cpu_out),
        .o_dout  (out_data),
        .o_full  (w_out_full),
        .o_empty (out_empty)
    );

`ifdef CPU_IO_CHECK_EN
    logic                w_exp_empty;
    logic                w_exp_full;
    logic [c_BYTE_W-1:0] w_exp_head;
    logic                w_exp_push;
    logic                r_done_prev;

    assign w_exp_push = exp_wr && (!w_exp_full || w_capture);

    io_fifo #(.DEPTH(DEPTH), .WIDTH(c_BYTE_W)) u_exp_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (w_exp_push),
        .i_pop   (w_capture),
        .i_din   (exp_data),
        .o_dout  (w_exp_head),
        .o_full  (w_exp_full),
        .o_empty (w_exp_empty)
    );

    // Score each capture against the expected head; no expectation is a fail
    always_ff @(posedge clock) begin
        if (reset) begin
            pass_count <= '0;
            fail_count <= '0;
        end else if (w_capture) begin
            if (!w_exp_empty && (w_exp_head == cpu_out)) begin
                if (pass_count != 4'd15) pass_count <= pass_count + 1'b1;
            end else begin
                if (fail_count != 4'd15) fail_count <= fail_count + 1'b1;
            end
        end
    end

    // Latch the verdict when the program signals completion
    always_ff @(posedge clock) begin
        if (reset) begin
            r_done_prev <= 1'b0;
            all_pass    <= 1'b0;
        end else begin
            r_done_prev <= cpu_done;
            if (cpu_done && !r_done_prev)
                all_pass <= (fail_count == 4'd0) && w_exp_empty;
        end
    end
`else
    // Completion only matters to the result-checking build
    logic w_unused_cpu_done;
    assign w_unused_cpu_done = cpu_done;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_io_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_io_controller
// Description : Directed self-checking bench for cpu_io_controller with a
//               queue-based reference model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_io_controller;

    localparam logic [3:0] IN_OP  = 4'b1010;
    localparam logic [3:0] OUT_OP = 4'b1011;
    localparam int         DEPTH  = 4;
    localparam int         ENTER  = 2;

    localparam int M_IDLE    = 0;
    localparam int M_WAIT    = 1;
    localparam int M_PRESENT = 2;
    localparam int M_RELEASE = 3;

    logic       clock;
    logic       reset;
    logic       in_wr;
    logic [7:0] in_data;
    logic       in_full;
    logic [3:0] opcode;
    logic [7:0] cpu_out;
    logic       cpu_done;
    logic [7:0] user_in;
    logic       enter;
    logic       out_rd;
    logic [7:0] out_data;
    logic       out_empty;
    logic       stall;
`ifdef CPU_IO_CHECK_EN
    logic       exp_wr;
    logic [7:0] exp_data;
    logic [3:0] pass_count;
    logic [3:0] fail_count;
    logic       all_pass;
`endif

    cpu_io_controller #(
        .IN_OPCODE    (IN_OP),
        .OUT_OPCODE   (OUT_OP),
        .DEPTH        (DEPTH),
        .ENTER_CYCLES (ENTER)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_wr     (in_wr),
        .in_data   (in_data),
        .in_full   (in_full),
        .opcode    (opcode),
        .cpu_out   (cpu_out),
        .cpu_done  (cpu_done),
        .user_in   (user_in),
        .enter     (enter),
        .out_rd    (out_rd),
        .out_data  (out_data),
        .out_empty (out_empty),
        .stall     (stall)
`ifdef CPU_IO_CHECK_EN
        ,
        .exp_wr     (exp_wr),
        .exp_data   (exp_data),
        .pass_count (pass_count),
        .fail_count (fail_count),
        .all_pass   (all_pass)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] m_in_q[$];
    logic [7:0] m_out_q[$];
    int         m_phase = M_IDLE;
    int         m_left  = 0;
    logic [7:0] m_user  = 8'h00;
    logic       m_prev_out = 1'b0;
    bit         m_valid = 1'b0;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%02h expected=%02h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit pop_in;
        bit capture;
        if (reset) begin
            m_in_q.delete();
            m_out_q.delete();
            m_phase    = M_IDLE;
            m_left     = 0;
            m_user     = 8'h00;
            m_prev_out = 1'b0;
            m_valid    = 1'b1;
        end else begin
            pop_in = (m_phase == M_PRESENT) && (m_left == 1);
            case (m_phase)
                M_IDLE:    if (opcode == IN_OP) m_phase = M_WAIT;
                M_WAIT:    if (m_in_q.size() != 0) begin
                               m_phase = M_PRESENT;
                               m_left  = ENTER;
                               m_user  = m_in_q[0];
                           end
                M_PRESENT: if (m_left == 1) m_phase = M_RELEASE;
                           else m_left--;
                M_RELEASE: if (opcode != IN_OP) m_phase = M_IDLE;
                default:   ;
            endcase
            if (pop_in && m_in_q.size() != 0) void'(m_in_q.pop_front());
            if (in_wr && m_in_q.size() < DEPTH) m_in_q.push_back(in_data);
            capture    = (opcode == OUT_OP) && !m_prev_out;
            m_prev_out = (opcode == OUT_OP);
            if (out_rd && m_out_q.size() != 0) void'(m_out_q.pop_front());
            if (capture && m_out_q.size() < DEPTH) m_out_q.push_back(cpu_out);
        end
    endtask

    task automatic compare();
        if (!m_valid) return;
        chk("enter",     {7'd0, enter},     {7'd0, m_phase == M_PRESENT});
        chk("user_in",   user_in,           m_user);
        chk("stall",     {7'd0, stall},     {7'd0, (m_phase == M_WAIT) && (m_in_q.size() == 0)});
        chk("in_full",   {7'd0, in_full},   {7'd0, m_in_q.size() == DEPTH});
        chk("out_empty", {7'd0, out_empty}, {7'd0, m_out_q.size() == 0});
        if (m_out_q.size() != 0) chk("out_data", out_data, m_out_q[0]);
    endtask

    // Model advances on each edge from the inputs held across it; outputs checked 2ns later
    initial begin
        forever begin
            @(posedge clock);
            model_step();
            #2;
            compare();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_in(input logic [7:0] d);
        in_wr   = 1'b1;
        in_data = d;
        tick(1);
        in_wr   = 1'b0;
    endtask

    task automatic deliver_one();
        opcode = IN_OP;
        tick(5);
        opcode = 4'h0;
        tick(2);
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; in_wr = 1'b0; in_data = 8'h00; opcode = 4'h0;
        cpu_out = 8'h00; cpu_done = 1'b0; out_rd = 1'b0;
`ifdef CPU_IO_CHECK_EN
        exp_wr = 1'b0; exp_data = 8'h00;
`endif
        tick(3);
        chk("rst_enter",     {7'd0, enter},     8'h00);
        chk("rst_user_in",   user_in,           8'h00);
        chk("rst_stall",     {7'd0, stall},     8'h00);
        chk("rst_in_full",   {7'd0, in_full},   8'h00);
        chk("rst_out_empty", {7'd0, out_empty}, 8'h01);
        reset = 1'b0;
        tick(1);

        // One byte delivered with a two-cycle strobe
        push_in(8'h04);
        opcode = IN_OP;
        tick(2);
        chk("t1_enter_c1", {7'd0, enter}, 8'h01);
        chk("t1_user_in",  user_in,       8'h04);
        tick(1);
        chk("t1_enter_c2", {7'd0, enter}, 8'h01);
        tick(1);
        chk("t1_enter_off", {7'd0, enter}, 8'h00);
        chk("t1_user_hold", user_in,       8'h04);
        opcode = 4'h0;
        tick(2);

        // CPU waits on an empty queue, then a late byte arrives
        opcode = IN_OP;
        tick(10);
        chk("t2_stall", {7'd0, stall}, 8'h01);
        chk("t2_enter", {7'd0, enter}, 8'h00);
        push_in(8'h07);
        tick(1);
        chk("t2_enter_on", {7'd0, enter}, 8'h01);
        chk("t2_user_in",  user_in,       8'h07);
        tick(3);
        opcode = 4'h0;
        tick(2);

        // One capture per OUT instruction regardless of its length
        opcode = OUT_OP; cpu_out = 8'h01;
        tick(3);
        opcode = 4'h0;
        tick(1);
        opcode = OUT_OP; cpu_out = 8'h00;
        tick(1);
        opcode = 4'h0;
        tick(1);
        chk("t3_not_empty", {7'd0, out_empty}, 8'h00);
        chk("t3_first",     out_data,          8'h01);
        out_rd = 1'b1; tick(1); out_rd = 1'b0;
        chk("t3_second", out_data, 8'h00);
        out_rd = 1'b1; tick(1); out_rd = 1'b0;
        chk("t3_empty", {7'd0, out_empty}, 8'h01);

        // Overfill the input queue, then pop and push together while full
        in_wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'h10 + 8'(i);
            tick(1);
            if (i == 2) chk("t4_not_full_3", {7'd0, in_full}, 8'h00);
            if (i == 3) chk("t4_full_4",     {7'd0, in_full}, 8'h01);
        end
        in_wr = 1'b0;
        chk("t4_full_after5", {7'd0, in_full}, 8'h01);
        opcode = IN_OP;
        tick(2);
        chk("t4_head", user_in, 8'h10);
        tick(1);
        in_wr = 1'b1; in_data = 8'h15;
        tick(1);
        in_wr = 1'b0;
        chk("t4_full_popush", {7'd0, in_full}, 8'h01);
        opcode = 4'h0;
        tick(2);
        repeat (4) deliver_one();
        chk("t4_last_byte", user_in,         8'h15);
        chk("t4_drained",   {7'd0, in_full}, 8'h00);

        // Reset while a byte is being presented
        opcode = OUT_OP; cpu_out = 8'hAA;
        tick(1);
        opcode = 4'h0;
        push_in(8'h09);
        opcode = IN_OP;
        tick(2);
        chk("t5_enter_on", {7'd0, enter}, 8'h01);
        chk("t5_user_in",  user_in,       8'h09);
        reset = 1'b1;
        tick(1);
        chk("t5_enter_off",  {7'd0, enter},     8'h00);
        chk("t5_user_clr",   user_in,           8'h00);
        chk("t5_out_empty",  {7'd0, out_empty}, 8'h01);
        chk("t5_in_not_full",{7'd0, in_full},   8'h00);
        reset = 1'b0; opcode = 4'h0;
        tick(2);

`ifdef CPU_IO_CHECK_EN
        // Matching results produce a passing verdict
        exp_wr = 1'b1; exp_data = 8'h01; tick(1);
        exp_data = 8'h00; tick(1);
        exp_wr = 1'b0;
        opcode = OUT_OP; cpu_out = 8'h01; tick(1);
        opcode = 4'h0; tick(1);
        opcode = OUT_OP; cpu_out = 8'h00; tick(1);
        opcode = 4'h0; tick(1);
        cpu_done = 1'b1; tick(1);
        chk("c1_pass", {4'd0, pass_count}, 8'h02);
        chk("c1_fail", {4'd0, fail_count}, 8'h00);
        chk("c1_all",  {7'd0, all_pass},   8'h01);
        cpu_done = 1'b0;
        reset = 1'b1; tick(1); reset = 1'b0; tick(1);

        // A wrong second result produces a failing verdict
        exp_wr = 1'b1; exp_data = 8'h01; tick(1);
        exp_data = 8'h00; tick(1);
        exp_wr = 1'b0;
        opcode = OUT_OP; cpu_out = 8'h01; tick(1);
        opcode = 4'h0; tick(1);
        opcode = OUT_OP; cpu_out = 8'h02; tick(1);
        opcode = 4'h0; tick(1);
        cpu_done = 1'b1; tick(1);
        chk("c2_pass", {4'd0, pass_count}, 8'h01);
        chk("c2_fail", {4'd0, fail_count}, 8'h01);
        chk("c2_all",  {7'd0, all_pass},   8'h00);
        cpu_done = 1'b0;
        tick(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
